// File: rtl/traffic_duration_ctrl.sv
// traffic_duration_ctrl
//   Holds the green/yellow/red duration registers shown on the LED display,
//   lets the user edit them with inc/dec buttons in the SET modes, and runs
//   the green -> yellow -> red light sequence from them in RUN mode.
//
// Ports
//   clk      system clock
//   rst_n    asynchronous reset, active low
//   tick     one-clk-wide 1 Hz enable pulse
//   sw       mode: 00 RUN, 01 SET_Y, 10 SET_G, 11 SET_R
//   btn_inc  increment button level (synchronized, debounced)
//   btn_dec  decrement button level (synchronized, debounced)
//   led_g    green duration register (1..15)
//   led_y    yellow duration register (1..15)
//   led_r    red duration register (1..15)
//   light    one-hot lamp drive {r,y,g}; 000 while in a SET mode
//   remain   seconds remaining in the current phase
module traffic_duration_ctrl #(
  parameter logic [3:0] DEF_G = 4'd5,
  parameter logic [3:0] DEF_Y = 4'd2,
  parameter logic [3:0] DEF_R = 4'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [1:0] sw,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [3:0] led_g,
  output logic [3:0] led_y,
  output logic [3:0] led_r,
  output logic [2:0] light,
  output logic [3:0] remain
);

  localparam logic [1:0] StGreen  = 2'd0;
  localparam logic [1:0] StYellow = 2'd1;
  localparam logic [1:0] StRed    = 2'd2;

  localparam logic [1:0] SwRun  = 2'b00;
  localparam logic [1:0] SwSetY = 2'b01;
  localparam logic [1:0] SwSetG = 2'b10;
  localparam logic [1:0] SwSetR = 2'b11;

  logic [1:0] state_q, state_d;
  logic [3:0] remain_q, remain_d;
  logic [3:0] led_g_q, led_g_d;
  logic [3:0] led_y_q, led_y_d;
  logic [3:0] led_r_q, led_r_d;
  logic       btn_inc_q, btn_dec_q;
  logic [1:0] sw_q;

  logic inc_p, dec_p;
  logic run_mode, restart;

  // Rising-edge pulses so a held button edits exactly once.
  assign inc_p = btn_inc & ~btn_inc_q;
  assign dec_p = btn_dec & ~btn_dec_q;

  assign run_mode = (sw == SwRun);
  assign restart  = run_mode && (sw_q != SwRun);

  // Saturating edit inside 1..15; simultaneous inc and dec cancel.
  function automatic logic [3:0] edit_dur(input logic [3:0] v, input logic up, input logic dn);
    logic [3:0] r;
    r = v;
    if (up && !dn && v != 4'd15) r = v + 4'd1;
    if (dn && !up && v > 4'd1)   r = v - 4'd1;
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    led_g_d  = led_g_q;
    led_y_d  = led_y_q;
    led_r_d  = led_r_q;

    if (run_mode) begin
      if (restart) begin
        // Returning from SET always restarts green with the edited duration;
        // a tick arriving in this same cycle is deliberately dropped.
        state_d  = StGreen;
        remain_d = led_g_q;
      end else if (tick) begin
        if (remain_q > 4'd1) begin
          remain_d = remain_q - 4'd1;
        end else begin
          case (state_q)
            StGreen: begin
              state_d  = StYellow;
              remain_d = led_y_q;
            end
            StYellow: begin
              state_d  = StRed;
              remain_d = led_r_q;
            end
            default: begin
              state_d  = StGreen;
              remain_d = led_g_q;
            end
          endcase
        end
      end
    end else begin
      case (sw)
        SwSetY:  led_y_d = edit_dur(led_y_q, inc_p, dec_p);
        SwSetG:  led_g_d = edit_dur(led_g_q, inc_p, dec_p);
        SwSetR:  led_r_d = edit_dur(led_r_q, inc_p, dec_p);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StGreen;
      remain_q  <= DEF_G;
      led_g_q   <= DEF_G;
      led_y_q   <= DEF_Y;
      led_r_q   <= DEF_R;
      btn_inc_q <= 1'b0;
      btn_dec_q <= 1'b0;
      sw_q      <= SwRun;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      led_g_q   <= led_g_d;
      led_y_q   <= led_y_d;
      led_r_q   <= led_r_d;
      btn_inc_q <= btn_inc;
      btn_dec_q <= btn_dec;
      sw_q      <= sw;
    end
  end

  // Lamps go dark as soon as a SET mode is selected.
  always_comb begin
    light = 3'b000;
    if (run_mode) begin
      case (state_q)
        StGreen:  light = 3'b001;
        StYellow: light = 3'b010;
        StRed:    light = 3'b100;
        default:  light = 3'b000;
      endcase
    end
  end

  assign led_g  = led_g_q;
  assign led_y  = led_y_q;
  assign led_r  = led_r_q;
  assign remain = remain_q;

endmodule

// File: tb/tb_traffic_duration_ctrl.sv
// Bench for traffic_duration_ctrl: a phase/duration model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_traffic_duration_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] sw = 2'b00;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [3:0] led_g, led_y, led_r, remain;
  logic [2:0] light;

  int checks = 0;
  int errors = 0;

  traffic_duration_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .sw      (sw),
    .btn_inc (btn_inc),
    .btn_dec (btn_dec),
    .led_g   (led_g),
    .led_y   (led_y),
    .led_r   (led_r),
    .light   (light),
    .remain  (remain)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: dur[0]=green, dur[1]=yellow, dur[2]=red; phase indexes dur.
  int dur[3];
  int phase;
  int rem;
  int prev_sw;
  bit prev_inc, prev_dec;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur[0] = 5; dur[1] = 2; dur[2] = 5;
      phase = 0; rem = 5;
      prev_sw = 0; prev_inc = 0; prev_dec = 0;
    end else begin
      bit ip, dp;
      int sel;
      ip = btn_inc && !prev_inc;
      dp = btn_dec && !prev_dec;
      if (sw == 2'b00) begin
        if (prev_sw != 0) begin
          phase = 0; rem = dur[0];
        end else if (tick) begin
          if (rem > 1) rem = rem - 1;
          else begin
            phase = (phase + 1) % 3;
            rem = dur[phase];
          end
        end
      end else begin
        sel = (sw == 2'b01) ? 1 : (sw == 2'b10) ? 0 : 2;
        if (ip && !dp && dur[sel] < 15) dur[sel] = dur[sel] + 1;
        if (dp && !ip && dur[sel] > 1)  dur[sel] = dur[sel] - 1;
      end
      prev_sw = int'(sw); prev_inc = btn_inc; prev_dec = btn_dec;
    end
  end

  // Every-cycle comparison just after the active edge.
  always @(posedge clk) begin
    #1;
    check("m_led_g", int'(led_g), dur[0]);
    check("m_led_y", int'(led_y), dur[1]);
    check("m_led_r", int'(led_r), dur[2]);
    check("m_remain", int'(remain), rem);
    check("m_light", int'(light), (sw == 2'b00) ? (1 << phase) : 0);
  end

  // Apply inputs for one edge; returns 2 time units after that edge.
  task automatic cyc(input bit t, input logic [1:0] s, input bit i, input bit d);
    tick = t; sw = s; btn_inc = i; btn_dec = d;
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cyc(1, 2'b00, 0, 0);
  endtask

  task automatic press_inc(input logic [1:0] s, input int n, input int hold);
    for (int k = 0; k < n; k++) begin
      for (int h = 0; h < hold; h++) cyc(0, s, 1, 0);
      cyc(0, s, 0, 0);
    end
  endtask

  task automatic press_dec(input logic [1:0] s, input int n);
    for (int k = 0; k < n; k++) begin
      cyc(0, s, 0, 1);
      cyc(0, s, 0, 0);
    end
  endtask

  initial begin
    #8;
    check("rst_led_g", int'(led_g), 5);
    check("rst_led_y", int'(led_y), 2);
    check("rst_led_r", int'(led_r), 5);
    check("rst_light", int'(light), 1);
    check("rst_remain", int'(remain), 5);
    #4 rst_n = 1'b1;
    @(posedge clk); #2;

    // 1: run sequence
    ticks(4);
    check("t1_remain1", int'(remain), 1);
    cyc(0, 2'b00, 0, 0);
    check("t1_hold", int'(remain), 1);
    ticks(1);
    check("t1_yel_light", int'(light), 3'b010);
    check("t1_yel_remain", int'(remain), 2);
    ticks(2);
    check("t1_red_light", int'(light), 3'b100);
    check("t1_red_remain", int'(remain), 5);
    ticks(5);
    check("t1_grn_light", int'(light), 3'b001);
    check("t1_grn_remain", int'(remain), 5);

    // 2: edit green, buttons held 4 clocks
    cyc(0, 2'b10, 0, 0);
    press_inc(2'b10, 3, 4);
    check("t2_led_g", int'(led_g), 8);
    check("t2_led_y", int'(led_y), 2);
    check("t2_led_r", int'(led_r), 5);
    check("t2_light", int'(light), 0);
    check("t2_remain", int'(remain), 5);

    // 3: saturation on yellow
    press_inc(2'b01, 20, 1);
    check("t3_sat_hi", int'(led_y), 15);
    press_dec(2'b01, 20);
    check("t3_sat_lo", int'(led_y), 1);

    // 4: simultaneous inc/dec on red
    cyc(0, 2'b11, 1, 1);
    cyc(0, 2'b11, 0, 0);
    check("t4_led_r", int'(led_r), 5);

    // 5: freeze mid-red, edit green, restart
    cyc(0, 2'b00, 0, 0);
    check("t5_restart_rem", int'(remain), 8);
    ticks(11);
    check("t5_red_light", int'(light), 3'b100);
    check("t5_red_rem", int'(remain), 3);
    cyc(1, 2'b10, 0, 0);
    check("t5_frozen_rem", int'(remain), 3);
    press_inc(2'b10, 1, 1);
    check("t5_led_g", int'(led_g), 9);
    cyc(1, 2'b00, 0, 0);
    check("t5_ret_light", int'(light), 3'b001);
    check("t5_ret_rem", int'(remain), 9);

    // 6: async reset mid-yellow with led_y=7
    press_inc(2'b01, 6, 1);
    check("t6_led_y", int'(led_y), 7);
    cyc(0, 2'b00, 0, 0);
    ticks(11);
    check("t6_yel_light", int'(light), 3'b010);
    check("t6_yel_rem", int'(remain), 5);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_led_y", int'(led_y), 2);
    check("t6_rst_led_g", int'(led_g), 5);
    check("t6_rst_light", int'(light), 1);
    check("t6_rst_remain", int'(remain), 5);
    repeat (3) @(posedge clk);
    #2;
    check("t6_hold_led_y", int'(led_y), 2);
    check("t6_hold_remain", int'(remain), 5);
    rst_n = 1'b1;
    ticks(2);
    check("t6_after_rem", int'(remain), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
